// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the memory-stage FSM encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } memacc_state_t;

endpackage

// File: rtl/access_timer.sv
// Wait counter for an outstanding data-memory access; flags when the wait budget is used up.
// Latency: expired is a pure compare on the registered count (valid in the same cycle).
// Backpressure: none; en advances the count, clr (higher priority) returns it to zero.
//
// Ports: CLK/nRST clock and synchronous active-low reset; en counts one waiting
// cycle; clr restarts the count; expired is high while the count equals TIMEOUT-1.
module access_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT - 1));

  // The count saturates at TIMEOUT-1; the owner aborts the access in that cycle
  // and clears the count on the following one.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/exmem_mem_access.sv
// Memory-stage controller behind the EX/MEM latch: issues dmem REN/WEN, stalls until dhit, captures load data.
// Latency: request issued combinationally in the cycle the instruction appears; dhit in that cycle costs 0 stalls.
// Backpressure: mem_stall freezes all pipeline latches while an access waits for dhit (dropped on timeout).
//
// Ports: ex_* are the latched EX/MEM fields (ex_valid = live instruction), pipe_hold
// is another hazard freezing EX/MEM; dhit/dmemload come from memory; dmemREN/WEN/
// addr/store go to memory; load_data feeds MEM/WB; halt and mem_err are sticky
// status bits; stall_cycles counts cycles with mem_stall high.
module exmem_mem_access
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ex_dren,
  input  logic             ex_dwen,
  input  logic             ex_halt,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_store,
  input  logic             ex_valid,
  input  logic             pipe_hold,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_stall,
  output logic [31:0]      load_data,
  output logic             halt,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  memacc_state_t    state;
  word_t            ld_q;
  logic             halt_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt;

  logic req;
  logic aligned;
  logic is_store;
  logic active;
  logic expired;

  assign req      = ex_valid & (ex_dren | ex_dwen) & ~halt_q & ~err_q;
  assign aligned  = (ex_addr[1:0] == 2'b00);
  assign is_store = ex_dwen;  // both enables set is treated as a store

  // "active" means a request is on the memory bus this cycle. The IDLE cycle in
  // which an aligned request shows up already counts as the first ACCESS cycle,
  // so the request is driven combinationally instead of from registered state.
  always_comb begin
    active = 1'b0;
    case (state)
      IDLE:    active = req & aligned;
      ACCESS:  active = 1'b1;
      default: active = 1'b0;
    endcase
    if (!nRST) active = 1'b0;
  end

  assign dmemREN   = active & ~is_store;
  assign dmemWEN   = active & is_store;
  // EX/MEM is frozen by mem_stall, so ex_addr/ex_store stay stable until dhit.
  assign dmemaddr  = active ? ex_addr  : 32'd0;
  assign dmemstore = active ? ex_store : 32'd0;
  // The pipeline advances in the dhit cycle itself, and also in the cycle the
  // access is abandoned on timeout.
  assign mem_stall = active & ~dhit & ~expired;

  assign load_data    = ld_q;
  assign halt         = halt_q;
  assign mem_err      = err_q;
  assign stall_cycles = stall_cnt;

  access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .en      (active & ~dhit),
    .clr     (~active | dhit),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      ld_q      <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (mem_stall) stall_cnt <= stall_cnt + CNT_W'(1);

      if (active && dhit && !is_store) ld_q <= dmemload;

      if (active) begin
        if (dhit) begin
          // If EX/MEM stays frozen, the served instruction is still sitting
          // there next cycle; DONE keeps it from being issued a second time.
          state <= pipe_hold ? DONE : IDLE;
        end else if (expired) begin
          err_q <= 1'b1;
          state <= IDLE;
        end else begin
          state <= ACCESS;
        end
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              // Only reachable for a misaligned address: never issued, retires
              // with load_data untouched.
              err_q <= 1'b1;
            end else if (ex_valid && ex_halt) begin
              halt_q <= 1'b1;
              state  <= HALTED;
            end
          end
          DONE: begin
            if (!pipe_hold || !ex_valid) state <= IDLE;
          end
          default: state <= state;  // HALTED is left only through reset
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exmem_mem_access.sv
// Self-checking bench for exmem_mem_access: vector table plus directed multi-cycle sequences.
// Latency: inputs driven 1 time unit after the rising edge, outputs compared 1 unit later.
// Backpressure: dhit and pipe_hold are driven directly by the stimulus.
module tb_exmem_mem_access;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_dren, ex_dwen, ex_halt, ex_valid, pipe_hold, dhit;
  logic [31:0] ex_addr, ex_store, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, halt, mem_err;
  logic [31:0] dmemaddr, dmemstore, load_data, stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  exmem_mem_access #(
    .TIMEOUT (8),
    .CNT_W   (32)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ex_dren      (ex_dren),
    .ex_dwen      (ex_dwen),
    .ex_halt      (ex_halt),
    .ex_addr      (ex_addr),
    .ex_store     (ex_store),
    .ex_valid     (ex_valid),
    .pipe_hold    (pipe_hold),
    .dhit         (dhit),
    .dmemload     (dmemload),
    .dmemREN      (dmemREN),
    .dmemWEN      (dmemWEN),
    .dmemaddr     (dmemaddr),
    .dmemstore    (dmemstore),
    .mem_stall    (mem_stall),
    .load_data    (load_data),
    .halt         (halt),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic        dren, dwen, hlt_in;
    logic [31:0] addr, store;
    logic        valid, hold, hit;
    logic [31:0] mload;
    logic        ren, wen, stall, err, hlt;
    logic [31:0] ld, sc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic dr, input logic dw, input logic hl, input logic [31:0] a,
                       input logic [31:0] s, input logic v, input logic ph, input logic h,
                       input logic [31:0] ml);
    ex_dren = dr; ex_dwen = dw; ex_halt = hl; ex_addr = a; ex_store = s;
    ex_valid = v; pipe_hold = ph; dhit = h; dmemload = ml;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_in();
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // dren, dwen, halt, addr, store, valid, hold, dhit, dmemload | ren, wen, stall, err, halt, load_data, stall_cycles
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h40,32'h0,1'b1,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,32'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,32'h40,32'h0,1'b1,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,32'd1};
    vecs[2]  = '{1'b1,1'b0,1'b0,32'h40,32'h0,1'b1,1'b0,1'b1,32'hDEADBEEF,   1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'd2};
    vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,           1'b0,1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF,32'd2};
    vecs[4]  = '{1'b0,1'b1,1'b0,32'h80,32'h12345678,1'b1,1'b0,1'b1,32'h0,   1'b0,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF,32'd2};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,           1'b0,1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF,32'd2};
    vecs[6]  = '{1'b1,1'b0,1'b0,32'h44,32'h0,1'b1,1'b1,1'b1,32'hCAFEF00D,   1'b1,1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF,32'd2};
    vecs[7]  = '{1'b1,1'b0,1'b0,32'h44,32'h0,1'b1,1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0,1'b0,32'hCAFEF00D,32'd2};
    vecs[8]  = '{1'b1,1'b0,1'b0,32'h44,32'h0,1'b1,1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0,1'b0,32'hCAFEF00D,32'd2};
    vecs[9]  = '{1'b1,1'b0,1'b0,32'h44,32'h0,1'b1,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0,1'b0,32'hCAFEF00D,32'd2};
    vecs[10] = '{1'b1,1'b0,1'b0,32'h48,32'h0,1'b1,1'b0,1'b1,32'h11112222,   1'b1,1'b0,1'b0,1'b0,1'b0,32'hCAFEF00D,32'd2};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,           1'b0,1'b0,1'b0,1'b0,1'b0,32'h11112222,32'd2};
    vecs[12] = '{1'b1,1'b1,1'b0,32'h50,32'hAAAA5555,1'b1,1'b0,1'b1,32'h99999999, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h11112222,32'd2};
    vecs[13] = '{1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,           1'b0,1'b0,1'b0,1'b0,1'b0,32'h11112222,32'd2};
    vecs[14] = '{1'b1,1'b0,1'b0,32'h42,32'h0,1'b1,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0,1'b0,32'h11112222,32'd2};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,           1'b0,1'b0,1'b0,1'b1,1'b0,32'h11112222,32'd2};
    vecs[16] = '{1'b1,1'b0,1'b0,32'h60,32'h0,1'b1,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b1,1'b0,32'h11112222,32'd2};

    // ---- reset state
    do_reset();
    #1;
    chk("rst_ren",   32'(dmemREN), 32'd0);
    chk("rst_wen",   32'(dmemWEN), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_err",   32'(mem_err), 32'd0);
    chk("rst_halt",  32'(halt), 32'd0);
    chk("rst_ld",    load_data, 32'd0);
    chk("rst_sc",    stall_cycles, 32'd0);
    chk("rst_addr",  dmemaddr, 32'd0);
    tick();

    // ---- vector table: one row per cycle
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].dren, vecs[i].dwen, vecs[i].hlt_in, vecs[i].addr, vecs[i].store,
            vecs[i].valid, vecs[i].hold, vecs[i].hit, vecs[i].mload);
      #1;
      chk($sformatf("v%0d_ren", i),   32'(dmemREN),   32'(vecs[i].ren));
      chk($sformatf("v%0d_wen", i),   32'(dmemWEN),   32'(vecs[i].wen));
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d_err", i),   32'(mem_err),   32'(vecs[i].err));
      chk($sformatf("v%0d_halt", i),  32'(halt),      32'(vecs[i].hlt));
      chk($sformatf("v%0d_ld", i),    load_data,      vecs[i].ld);
      chk($sformatf("v%0d_sc", i),    stall_cycles,   vecs[i].sc);
      if (vecs[i].ren || vecs[i].wen)
        chk($sformatf("v%0d_addr", i), dmemaddr, vecs[i].addr);
      if (vecs[i].wen)
        chk($sformatf("v%0d_store", i), dmemstore, vecs[i].store);
      tick();
    end

    // ---- timeout: TIMEOUT=8, dhit never arrives
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("to%0d_ren", i),   32'(dmemREN), 32'd1);
      chk($sformatf("to%0d_addr", i),  dmemaddr, 32'h100);
      chk($sformatf("to%0d_stall", i), 32'(mem_stall), (i < 7) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("to_drop_ren",  32'(dmemREN), 32'd0);
    chk("to_err",       32'(mem_err), 32'd1);
    chk("to_stall_low", 32'(mem_stall), 32'd0);
    chk("to_sc",        stall_cycles, 32'd7);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h104, 32'h5, 1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    chk("to_ignored_wen", 32'(dmemWEN), 32'd0);
    tick();

    // ---- reset clears mem_err and stall_cycles
    do_reset();
    #1;
    chk("rst2_err", 32'(mem_err), 32'd0);
    chk("rst2_sc",  stall_cycles, 32'd0);

    // ---- store (dhit after 2 cycles) then halt
    drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("st1_wen",   32'(dmemWEN), 32'd1);
    chk("st1_stall", 32'(mem_stall), 32'd1);
    tick();
    dhit = 1'b1;
    #1;
    chk("st2_wen",   32'(dmemWEN), 32'd1);
    chk("st2_data",  dmemstore, 32'h0BADF00D);
    chk("st2_stall", 32'(mem_stall), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("hl_pre", 32'(halt), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    chk("hl_set",    32'(halt), 32'd1);
    chk("hl_no_ren", 32'(dmemREN), 32'd0);
    chk("hl_sc",     stall_cycles, 32'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h208, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    chk("hl_no_wen", 32'(dmemWEN), 32'd0);
    tick();
    do_reset();
    #1;
    chk("rst3_halt", 32'(halt), 32'd0);
    chk("rst3_sc",   stall_cycles, 32'd0);

    // ---- reset in the middle of an access
    drive(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    #1;
    chk("mid_sc", stall_cycles, 32'd2);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    idle_in();
    #1;
    chk("mid_ren", 32'(dmemREN), 32'd0);
    chk("mid_sc0", stall_cycles, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    #1;
    chk("mid_new_ren",   32'(dmemREN), 32'd1);
    chk("mid_new_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_in();
    #1;
    chk("mid_new_ld", load_data, 32'h5A5A5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
